// File: rtl/loader_pkg.sv
// Shared constants and types for the boot-time instruction loader.
// Holds the end-of-program marker, the FSM encoding and the FIFO pointer-width helper.
package loader_pkg;

  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } state_e;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO; DEPTH must be a power of two (pointers wrap naturally).
// A pop frees a slot in the same cycle, so push+pop on a full FIFO succeeds.
module byte_fifo
  import loader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Stale storage is masked so the head reads 0 whenever nothing is queued.
  assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: packs UART bytes big-endian into 32-bit instruction words until 32'hFFFFFFFF,
// then forwards later bytes through a byte FIFO. Define INST_LOADER_CHECKSUM_EN for a write checksum.
module inst_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int MAX_WORDS  = 3578,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_changed,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              load_overflow,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rx_drop,
  output logic [31:0]       checksum
);

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       shreg_q, shreg_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              load_overflow_q, load_overflow_d;
  logic              rx_drop_q, rx_drop_d;

  logic [31:0] word;
  logic        word_last;
  logic        mem_full;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;

  // Only 24 bits of history are needed: the 4th byte completes the word combinationally.
  assign word      = {shreg_q, rx_data};
  assign word_last = (state_q == LOAD) && rx_changed && (byte_idx_q == 2'd3);
  assign mem_full  = (word_count_q >= (ADDR_W+1)'(MAX_WORDS));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (word_last && (word == END_MARKER)) state_d = DONE;
  end

  // FSM: outputs
  always_comb begin
    done      = (state_q == DONE);
    fifo_push = done && rx_changed;
    fifo_pop  = done && out_ready;
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    byte_idx_d      = byte_idx_q;
    shreg_d         = shreg_q;
    mem_we_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    word_count_d    = word_count_q;
    load_overflow_d = load_overflow_q;
    rx_drop_d       = rx_drop_q;
    if ((state_q == LOAD) && rx_changed) begin
      shreg_d    = word[23:0];
      byte_idx_d = byte_idx_q + 2'd1;
      if (word_last && (word != END_MARKER)) begin
        if (!mem_full) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = word_count_q[ADDR_W-1:0];
          mem_wdata_d  = word;
          word_count_d = word_count_q + 1'b1;
        end else begin
          load_overflow_d = 1'b1;
        end
      end
    end
    if (fifo_push && fifo_full && !fifo_pop) rx_drop_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignment only; comb blocks use blocking.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx_q      <= '0;
      shreg_q         <= '0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      word_count_q    <= '0;
      load_overflow_q <= 1'b0;
      rx_drop_q       <= 1'b0;
    end else begin
      byte_idx_q      <= byte_idx_d;
      shreg_q         <= shreg_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      word_count_q    <= word_count_d;
      load_overflow_q <= load_overflow_d;
      rx_drop_q       <= rx_drop_d;
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  // Accumulated alongside the registered write, so it moves in the same cycle as mem_we.
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (mem_we_d) checksum_d = checksum_q + word;
  end

  always_ff @(posedge clk) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (rx_data),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (out_data),
    .empty (fifo_empty)
  );

  assign out_valid     = !fifo_empty;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign word_count    = word_count_q;
  assign load_overflow = load_overflow_q;
  assign rx_drop       = rx_drop_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed testbench for inst_loader: word loading, end marker, post-load FIFO, reset and overflow.
// A second instance with MAX_WORDS=2 covers the capacity limit.
module tb_inst_loader;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_changed = 1'b0;
  logic              out_ready = 1'b0;

  logic              mem_we, done, load_overflow, out_valid, rx_drop;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, checksum;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        out_data;

  logic              s_mem_we, s_done, s_load_overflow, s_out_valid, s_rx_drop;
  logic [ADDR_W-1:0] s_mem_addr;
  logic [31:0]       s_mem_wdata, s_checksum;
  logic [ADDR_W:0]   s_word_count;
  logic [7:0]        s_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  logic [ADDR_W-1:0] s_wr_addr[$];
  logic [31:0]       s_wr_data[$];

  inst_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(3578), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_changed(rx_changed),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done),
    .word_count(word_count), .load_overflow(load_overflow), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .rx_drop(rx_drop), .checksum(checksum)
  );

  inst_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(2), .FIFO_DEPTH(8)) dut_small (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_changed(rx_changed),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .done(s_done),
    .word_count(s_word_count), .load_overflow(s_load_overflow), .out_data(s_out_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .rx_drop(s_rx_drop), .checksum(s_checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we)   begin wr_addr.push_back(mem_addr);     wr_data.push_back(mem_wdata);     end
    if (s_mem_we) begin s_wr_addr.push_back(s_mem_addr); s_wr_data.push_back(s_mem_wdata); end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic strobe(input logic [7:0] b);
    rx_data    = b;
    rx_changed = 1'b1;
    @(negedge clk);
    rx_changed = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) strobe(w[31-8*i -: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves reset asserted for one edge; callers check outputs before releasing it.
  task automatic apply_reset();
    reset      = 1'b1;
    rx_changed = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    wr_addr.delete(); wr_data.delete();
    s_wr_addr.delete(); s_wr_data.delete();
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, done, word_count, load_overflow, out_data, out_valid,
         rx_drop, checksum} !== '0) begin
      n_fail++;
      $display("FAIL %s: main outputs not all zero (we=%b addr=%h wdata=%h done=%b cnt=%h ovf=%b od=%h ov=%b drop=%b cs=%h)",
               name, mem_we, mem_addr, mem_wdata, done, word_count, load_overflow, out_data,
               out_valid, rx_drop, checksum);
    end
    n_checks++;
    if ({s_mem_we, s_mem_addr, s_mem_wdata, s_done, s_word_count, s_load_overflow, s_out_data,
         s_out_valid, s_rx_drop, s_checksum} !== '0) begin
      n_fail++;
      $display("FAIL %s_small: small-instance outputs not all zero", name);
    end
  endtask

  task automatic test_reset();
    idle(2);
    apply_reset();
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset(); reset = 1'b0;
    send_word(32'h12345678);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 14'd0, 32'h12345678}) begin
      n_fail++;
      $display("FAIL basic_write: got we=%b addr=%0d data=%h, expected we=1 addr=0 data=12345678",
               mem_we, mem_addr, mem_wdata);
    end
    n_checks++;
    if (word_count !== 15'd1) begin
      n_fail++; $display("FAIL basic_count: got %0d expected 1", word_count);
    end
    strobe(8'hFF);
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL basic_we_pulse: mem_we got %b expected 0", mem_we);
    end
    strobe(8'hFF); strobe(8'hFF);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_early: done got %b expected 0", done);
    end
    strobe(8'hFF);
    n_checks++;
    if ({done, word_count} !== {1'b1, 15'd1}) begin
      n_fail++; $display("FAIL basic_done: got done=%b cnt=%0d expected done=1 cnt=1", done, word_count);
    end
    idle(2);
    n_checks++;
    if (wr_addr.size() != 1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL basic_writes: got %0d writes we=%b expected 1 write we=0", wr_addr.size(), mem_we);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_cs;
    apply_reset(); reset = 1'b0;
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000003);
    send_word(32'hFFFFFFFF);
    idle(2);
`ifdef INST_LOADER_CHECKSUM_EN
    exp_cs = 32'd6;
`else
    exp_cs = 32'd0;
`endif
    n_checks++;
    if (wr_addr.size() != 3) begin
      n_fail++; $display("FAIL b2b_writes: got %0d writes expected 3", wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== 32'(i + 1)) begin
          n_fail++;
          $display("FAIL b2b_write%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                   i, wr_addr[i], wr_data[i], i, i + 1);
        end
      end
    end
    n_checks++;
    if ({done, word_count, load_overflow} !== {1'b1, 15'd3, 1'b0}) begin
      n_fail++; $display("FAIL b2b_status: got done=%b cnt=%0d ovf=%b expected 1/3/0", done, word_count, load_overflow);
    end
    n_checks++;
    if (checksum !== exp_cs) begin
      n_fail++; $display("FAIL b2b_checksum: got %h expected %h", checksum, exp_cs);
    end
  endtask

  // Runs in DONE, right after test_back_to_back.
  task automatic test_fifo_stream();
    logic [7:0] b;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      strobe(b);
      n_checks++;
      if ({out_valid, out_data} !== {1'b1, b}) begin
        n_fail++; $display("FAIL stream_byte%0d: got valid=%b data=%h expected 1/%h", i, out_valid, out_data, b);
      end
    end
    idle(1);
    n_checks++;
    if ({out_valid, rx_drop, mem_we} !== 3'b000) begin
      n_fail++; $display("FAIL stream_end: got valid=%b drop=%b we=%b expected 0/0/0", out_valid, rx_drop, mem_we);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      strobe(8'h21 + 8'(i));
      if (i == 7) begin
        n_checks++;
        if (rx_drop !== 1'b0) begin
          n_fail++; $display("FAIL full_no_drop_at_8: rx_drop got %b expected 0", rx_drop);
        end
      end
    end
    idle(2);
    n_checks++;
    if ({rx_drop, out_valid, out_data} !== {1'b1, 1'b1, 8'h21}) begin
      n_fail++; $display("FAIL full_hold: got drop=%b valid=%b data=%h expected 1/1/21", rx_drop, out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'h21 + 8'(i);
      n_checks++;
      if ({out_valid, out_data} !== {1'b1, b}) begin
        n_fail++; $display("FAIL full_pop%0d: got valid=%b data=%h expected 1/%h", i, out_valid, out_data, b);
      end
      @(negedge clk);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_drained: out_valid got %b expected 0", out_valid);
    end
    // Refill to full, then push and pop in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) strobe(8'h41 + 8'(i));
    out_ready = 1'b1;
    strobe(8'h49);
    for (int i = 0; i < 8; i++) begin
      b = 8'h42 + 8'(i);
      n_checks++;
      if ({out_valid, out_data} !== {1'b1, b}) begin
        n_fail++; $display("FAIL full_pushpop%0d: got valid=%b data=%h expected 1/%h", i, out_valid, out_data, b);
      end
      @(negedge clk);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL pushpop_drained: out_valid got %b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    strobe(8'h55); strobe(8'h66); strobe(8'h77);
    apply_reset();
    check_all_zero("reset_mid_stream");
    reset = 1'b0;
    strobe(8'hAA); strobe(8'hBB);
    apply_reset(); reset = 1'b0;
    send_word(32'hDEADBEEF);
    send_word(32'hFFFFFFFF);
    idle(2);
    n_checks++;
    if (wr_addr.size() != 1) begin
      n_fail++; $display("FAIL midword_writes: got %0d writes expected 1", wr_addr.size());
    end else begin
      n_checks++;
      if (wr_addr[0] !== 14'd0 || wr_data[0] !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL midword_data: got addr=%0d data=%h expected 0/deadbeef", wr_addr[0], wr_data[0]);
      end
    end
    n_checks++;
    if ({done, word_count, out_valid} !== {1'b1, 15'd1, 1'b0}) begin
      n_fail++; $display("FAIL midword_status: got done=%b cnt=%0d valid=%b expected 1/1/0", done, word_count, out_valid);
    end
  endtask

  task automatic test_overflow();
    apply_reset(); reset = 1'b0;
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000003);
    n_checks++;
    if ({s_mem_we, s_load_overflow} !== 2'b01) begin
      n_fail++; $display("FAIL ovf_drop: got we=%b ovf=%b expected 0/1", s_mem_we, s_load_overflow);
    end
    send_word(32'hFFFFFFFF);
    idle(2);
    n_checks++;
    if (s_wr_addr.size() != 2) begin
      n_fail++; $display("FAIL ovf_writes: got %0d writes expected 2", s_wr_addr.size());
    end else begin
      n_checks++;
      if ({s_wr_addr[0], s_wr_data[0], s_wr_addr[1], s_wr_data[1]} !==
          {14'd0, 32'd1, 14'd1, 32'd2}) begin
        n_fail++;
        $display("FAIL ovf_data: got %0d:%h %0d:%h expected 0:00000001 1:00000002",
                 s_wr_addr[0], s_wr_data[0], s_wr_addr[1], s_wr_data[1]);
      end
    end
    n_checks++;
    if ({s_load_overflow, s_word_count, s_done} !== {1'b1, 15'd2, 1'b1}) begin
      n_fail++; $display("FAIL ovf_status: got ovf=%b cnt=%0d done=%b expected 1/2/1", s_load_overflow, s_word_count, s_done);
    end
    n_checks++;
    if ({load_overflow, word_count} !== {1'b0, 15'd3}) begin
      n_fail++; $display("FAIL ovf_big_instance: got ovf=%b cnt=%0d expected 0/3", load_overflow, word_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_fifo_stream();
    test_fifo_full();
    test_reset_mid();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
